// File: rtl/wb_prog_loader_if.sv
// Bus bundle for the program loader: Wishbone slave side plus program-memory handshake.
// The slave modport is the loader's view; master is the SoC/memory environment.
interface wb_prog_loader_if #(
  parameter int unsigned CORE_BITS = 3,
  parameter int unsigned PC_BITS   = 8
);
  logic                 wbs_stb_i;
  logic                 wbs_cyc_i;
  logic                 wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_adr_i;
  logic [31:0]          wbs_dat_i;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;

  logic                 mem_req;
  logic                 mem_we;
  logic [CORE_BITS-1:0] mem_core;
  logic [PC_BITS-1:0]   mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;
  logic                 mem_ready;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output mem_req, mem_we, mem_core, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  mem_req, mem_we, mem_core, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/wb_prog_loader.sv
// Wishbone slave that turns management-SoC cycles into per-core program-memory
// handshakes and hosts the CTRL/ID register bank driving the per-core reset mask.
module wb_prog_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h30,
  parameter int unsigned CORE_BITS = 3,
  parameter int unsigned PC_BITS   = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wb_prog_loader_if.slave         bus,
  output logic [2**CORE_BITS-1:0] core_rst
);

  localparam int unsigned NCORES   = 2 ** CORE_BITS;
  localparam logic [31:0] ID_VALUE = 32'h7472_6565;
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StMem, StAck, StGap} state_e;

  state_e state_q, state_d;

  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [CORE_BITS-1:0] core_q, core_d;
  logic [PC_BITS-1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [NCORES-1:0]    core_rst_q, core_rst_d;
  logic                 err_q, err_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 abort_q, abort_d;

  logic        hit, is_reg, bad_sel, timeout, err_set, err_clr;
  logic [1:0]  reg_idx;
  logic [31:0] reg_rdata;
  logic        unused_adr;

  assign hit     = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE_ADDR);
  assign is_reg  = bus.wbs_adr_i[23];
  assign reg_idx = bus.wbs_adr_i[3:2];
  assign bad_sel = bus.wbs_we_i & (bus.wbs_sel_i != 4'hF);
  assign timeout = (tmo_q == TMO_LAST);

  assign unused_adr = ^{bus.wbs_adr_i[22:CORE_BITS+PC_BITS+2], bus.wbs_adr_i[1:0]};

  always_comb begin
    reg_rdata = '0;
    unique case (reg_idx)
      2'd0: begin
        reg_rdata[NCORES-1:0] = core_rst_q;
        reg_rdata[31]         = err_q;
      end
      2'd1:    reg_rdata = ID_VALUE;
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hit) state_d = (is_reg || bad_sel) ? StAck : StMem;
      end
      StMem: begin
        // An abandoned master still lets the memory finish, but gets no ack.
        if (bus.mem_ready || timeout) begin
          state_d = (abort_q || !bus.wbs_cyc_i) ? StGap : StAck;
        end
      end
      StAck:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_d      = 1'b0;
    dat_d      = '0;
    req_d      = req_q;
    we_d       = we_q;
    core_d     = core_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    tmo_d      = tmo_q;
    abort_d    = abort_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          if (is_reg) begin
            ack_d = 1'b1;
            if (!bus.wbs_we_i) begin
              dat_d = reg_rdata;
            end else if (reg_idx == 2'd0) begin
              for (int i = 0; i < NCORES; i++) begin
                if (bus.wbs_sel_i[i/8]) core_rst_d[i] = bus.wbs_dat_i[i];
              end
              err_clr = bus.wbs_sel_i[3] & bus.wbs_dat_i[31];
            end
          end else if (bad_sel) begin
            ack_d   = 1'b1;
            err_set = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = bus.wbs_we_i;
            core_d  = bus.wbs_adr_i[CORE_BITS+PC_BITS+1:PC_BITS+2];
            addr_d  = bus.wbs_adr_i[PC_BITS+1:2];
            wdata_d = bus.wbs_dat_i;
            tmo_d   = '0;
            abort_d = 1'b0;
          end
        end
      end
      StMem: begin
        tmo_d = tmo_q + 8'd1;
        if (!bus.wbs_cyc_i) abort_d = 1'b1;
        if (bus.mem_ready || timeout) begin
          req_d = 1'b0;
          ack_d = ~abort_q & bus.wbs_cyc_i;
          if (!bus.mem_ready) begin
            err_set = 1'b1;
            if (ack_d) dat_d = TMO_DATA;
          end else if (!we_q && ack_d) begin
            dat_d = bus.mem_rdata;
          end
        end
      end
      default: ;
    endcase
    // A simultaneous set beats the write-1-to-clear.
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      core_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= '1;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      abort_q    <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      req_q      <= req_d;
      we_q       <= we_d;
      core_q     <= core_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_core  = core_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst      = core_rst_q;

endmodule
